// File: rtl/id_stage_pipe.sv
// -----------------------------------------------------------------------------
// id_stage_pipe
//   Registered instruction-decode stage.
//   Decodes the instruction offered by IF, reads up to three regfile sources
//   (with N-source forwarding), and captures operands, control and PC into
//   the ID/EX register.
//   It also detects a load-use hazard against the instruction in EX and
//   stalls on it. A taken BEQ resolves here: it raises a one-cycle br pulse
//   to IF, and the instruction accepted during that pulse is squashed.
//
// Ports
//   clk, reset_n                 clock, synchronous active-low reset
//   in_valid/in_ready            IF -> ID handshake
//   in_pc, in_inst               instruction PC and word
//   rN_addr/rN_read_enable       regfile read ports (combinational, N=1..3)
//   rN_data                      regfile read data (same cycle)
//   fwd_valid/fwd_addr/fwd_data  packed forwarding sources, index 0 youngest
//   ex_is_load, ex_rd_addr       load-use hazard inputs from EX
//   out_valid/out_ready          ID -> EX handshake
//   op_1/op_2/op_3               registered operands
//   mem_offset                   registered sign-extended I/S offset
//   rd_addr, rd_we, alu_op       registered destination and ALU control
//   pc_out, ID_inst              registered PC and instruction word
//   br, branch_addr              taken-branch pulse and target to IF
//
// Optional build macro ID_PERF_CNT_EN adds stall_cnt, squash_cnt, taken_cnt.
//
// Local encodings: standard RV32I opcodes/functs.
//   MAC uses custom-0 (0001011), funct3=000, funct7=0.
//   Its rs3 (accumulator) is inst[11:7], which is also rd.
// -----------------------------------------------------------------------------
module id_stage_pipe #(
    parameter int XLEN    = 32,
    parameter int RA_W    = 5,
    parameter int ALUOP_W = 4,
    parameter int NFWD    = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [31:0]          in_inst,
    output logic [RA_W-1:0]      r1_addr,
    output logic [RA_W-1:0]      r2_addr,
    output logic [RA_W-1:0]      r3_addr,
    output logic                 r1_read_enable,
    output logic                 r2_read_enable,
    output logic                 r3_read_enable,
    input  logic [XLEN-1:0]      r1_data,
    input  logic [XLEN-1:0]      r2_data,
    input  logic [XLEN-1:0]      r3_data,
    input  logic [NFWD-1:0]      fwd_valid,
    input  logic [NFWD*RA_W-1:0] fwd_addr,
    input  logic [NFWD*XLEN-1:0] fwd_data,
    input  logic                 ex_is_load,
    input  logic [RA_W-1:0]      ex_rd_addr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      op_1,
    output logic [XLEN-1:0]      op_2,
    output logic [XLEN-1:0]      op_3,
    output logic [XLEN-1:0]      mem_offset,
    output logic [RA_W-1:0]      rd_addr,
    output logic                 rd_we,
    output logic [ALUOP_W-1:0]   alu_op,
    output logic [XLEN-1:0]      pc_out,
    output logic [31:0]          ID_inst,
    output logic                 br,
    output logic [XLEN-1:0]      branch_addr
`ifdef ID_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          squash_cnt,
    output logic [31:0]          taken_cnt
`endif
);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_MAC    = 7'b0001011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(2);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3);
    localparam logic [ALUOP_W-1:0] ALU_SLL = ALUOP_W'(4);
    localparam logic [ALUOP_W-1:0] ALU_SRA = ALUOP_W'(5);
    localparam logic [ALUOP_W-1:0] ALU_MAC = ALUOP_W'(6);

    // ---------------------------------------------------------------- fields
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b;

    assign opcode = in_inst[6:0];
    assign funct3 = in_inst[14:12];
    assign funct7 = in_inst[31:25];
    assign imm_i  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
    assign imm_s  = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b  = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7],
                     in_inst[30:25], in_inst[11:8], 1'b0};

    // ---------------------------------------------------------------- decode
    logic               dec_ok, dec_we, is_beq, is_addi;
    logic               en1, en2, en3;
    logic [ALUOP_W-1:0] dec_alu;
    logic [XLEN-1:0]    dec_off;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        dec_ok  = 1'b0;
        dec_we  = 1'b0;
        is_beq  = 1'b0;
        is_addi = 1'b0;
        en1     = 1'b0;
        en2     = 1'b0;
        en3     = 1'b0;
        dec_alu = ALU_ADD;
        dec_off = '0;
        case (opcode)
            OPC_R: begin
                dec_ok = 1'b1;
                case ({funct7, funct3})
                    {F7_BASE, 3'b000}: dec_alu = ALU_ADD;
                    {F7_ALT,  3'b000}: dec_alu = ALU_SUB;
                    {F7_BASE, 3'b001}: dec_alu = ALU_SLL;
                    {F7_ALT,  3'b101}: dec_alu = ALU_SRA;
                    {F7_BASE, 3'b110}: dec_alu = ALU_OR;
                    {F7_BASE, 3'b111}: dec_alu = ALU_AND;
                    default:           dec_ok  = 1'b0;
                endcase
                en1    = dec_ok;
                en2    = dec_ok;
                dec_we = dec_ok;
            end
            OPC_IMM: if (funct3 == 3'b000) begin
                dec_ok  = 1'b1;
                en1     = 1'b1;
                dec_we  = 1'b1;
                is_addi = 1'b1;
            end
            OPC_LOAD: if (funct3 == 3'b010) begin
                dec_ok  = 1'b1;
                en1     = 1'b1;
                dec_we  = 1'b1;
                dec_off = imm_i;
            end
            OPC_STORE: if (funct3 == 3'b010) begin
                dec_ok  = 1'b1;
                en1     = 1'b1;
                en2     = 1'b1;
                dec_off = imm_s;
            end
            OPC_BRANCH: if (funct3 == 3'b000) begin
                dec_ok  = 1'b1;
                en1     = 1'b1;
                en2     = 1'b1;
                is_beq  = 1'b1;
                dec_alu = ALU_SUB;
            end
            OPC_MAC: if (funct3 == 3'b000 && funct7 == F7_BASE) begin
                dec_ok  = 1'b1;
                en1     = 1'b1;
                en2     = 1'b1;
                en3     = 1'b1;
                dec_we  = 1'b1;
                dec_alu = ALU_MAC;
            end
            default: ;
        endcase
    end

    // Disabled sources present address 0, which also makes the operand
    // selector below return 0 for them without a separate enable term.
    assign r1_read_enable = en1;
    assign r2_read_enable = en2;
    assign r3_read_enable = en3;
    assign r1_addr = en1 ? RA_W'(in_inst[19:15]) : '0;
    assign r2_addr = en2 ? RA_W'(in_inst[24:20]) : '0;
    assign r3_addr = en3 ? RA_W'(in_inst[11:7])  : '0;

    // ------------------------------------------------------ operand forwarding
    // Scan from oldest to youngest so the lowest matching index wins.
    function automatic logic [XLEN-1:0] fwd_sel(input logic [RA_W-1:0] addr,
                                                 input logic [XLEN-1:0] rf_val);
        logic [XLEN-1:0] val;
        val = rf_val;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_valid[i] && fwd_addr[i*RA_W +: RA_W] == addr)
                val = fwd_data[i*XLEN +: XLEN];
        end
        if (addr == '0)
            val = '0;
        return val;
    endfunction

    logic [XLEN-1:0] src1, src2, src3, opb;
    assign src1 = fwd_sel(r1_addr, r1_data);
    assign src2 = fwd_sel(r2_addr, r2_data);
    assign src3 = fwd_sel(r3_addr, r3_data);
    assign opb  = is_addi ? imm_i : src2;

    // --------------------------------------------------------------- control
    logic stall, adv, xfer, issue, taken;

    // Forwarding cannot help a load still in EX, so any match stalls.
    assign stall = ex_is_load && (ex_rd_addr != '0) &&
                   ((en1 && r1_addr == ex_rd_addr) ||
                    (en2 && r2_addr == ex_rd_addr) ||
                    (en3 && r3_addr == ex_rd_addr));

    assign adv      = out_ready || !out_valid;
    assign in_ready = reset_n && !stall && adv;
    assign xfer     = in_valid && in_ready;
    // While br is high the transferred instruction is on the wrong path.
    assign issue    = xfer && dec_ok && !br;
    assign taken    = issue && is_beq && (src1 == src2);

    // -------------------------------------------------------- ID/EX register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            out_valid   <= 1'b0;
            op_1        <= '0;
            op_2        <= '0;
            op_3        <= '0;
            mem_offset  <= '0;
            rd_addr     <= '0;
            rd_we       <= 1'b0;
            alu_op      <= '0;
            pc_out      <= '0;
            ID_inst     <= '0;
            br          <= 1'b0;
            branch_addr <= '0;
        end else begin
            br <= taken;
            if (taken)
                branch_addr <= in_pc + imm_b;
            if (adv) begin
                out_valid <= issue;
                if (issue) begin
                    op_1       <= src1;
                    op_2       <= opb;
                    op_3       <= src3;
                    mem_offset <= dec_off;
                    rd_addr    <= dec_we ? RA_W'(in_inst[11:7]) : '0;
                    rd_we      <= dec_we;
                    alu_op     <= dec_alu;
                    pc_out     <= in_pc;
                    ID_inst    <= in_inst;
                end
            end
        end
    end

`ifdef ID_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt  <= '0;
            squash_cnt <= '0;
            taken_cnt  <= '0;
        end else begin
            if (stall && in_valid)
                stall_cnt <= stall_cnt + 32'd1;
            if (xfer && br)
                squash_cnt <= squash_cnt + 32'd1;
            if (br)
                taken_cnt <= taken_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
module tb_id_stage_pipe;

    localparam logic [6:0] R_OP = 7'b0110011;
    localparam logic [6:0] I_OP = 7'b0010011;
    localparam logic [6:0] L_OP = 7'b0000011;
    localparam logic [6:0] S_OP = 7'b0100011;
    localparam logic [6:0] M_OP = 7'b0001011;

    localparam logic [3:0] A_ADD = 4'd0;
    localparam logic [3:0] A_SUB = 4'd1;
    localparam logic [3:0] A_SRA = 4'd5;
    localparam logic [3:0] A_MAC = 4'd6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_inst;
    logic [4:0]  r1_addr, r2_addr, r3_addr;
    logic        r1_read_enable, r2_read_enable, r3_read_enable;
    logic [31:0] r1_data, r2_data, r3_data;
    logic [1:0]  fwd_valid;
    logic [9:0]  fwd_addr;
    logic [63:0] fwd_data;
    logic        ex_is_load;
    logic [4:0]  ex_rd_addr;
    logic        out_valid, out_ready;
    logic [31:0] op_1, op_2, op_3, mem_offset;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [3:0]  alu_op;
    logic [31:0] pc_out, ID_inst;
    logic        br;
    logic [31:0] branch_addr;
`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt, squash_cnt, taken_cnt;
`endif

    logic [31:0] rf [32];
    assign r1_data = rf[r1_addr];
    assign r2_data = rf[r2_addr];
    assign r3_data = rf[r3_addr];

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .r1_addr(r1_addr), .r2_addr(r2_addr), .r3_addr(r3_addr),
        .r1_read_enable(r1_read_enable), .r2_read_enable(r2_read_enable),
        .r3_read_enable(r3_read_enable),
        .r1_data(r1_data), .r2_data(r2_data), .r3_data(r3_data),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .ex_is_load(ex_is_load), .ex_rd_addr(ex_rd_addr),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_1(op_1), .op_2(op_2), .op_3(op_3), .mem_offset(mem_offset),
        .rd_addr(rd_addr), .rd_we(rd_we), .alu_op(alu_op),
        .pc_out(pc_out), .ID_inst(ID_inst),
        .br(br), .branch_addr(branch_addr)
`ifdef ID_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .squash_cnt(squash_cnt), .taken_cnt(taken_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] op1, op2, op3, off;
        logic [4:0]  rd;
        logic        we;
        logic [3:0]  alu;
        logic [31:0] pc, inst;
    } exp_t;

    exp_t sb [$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {f7, rs2, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] s_t(input logic [11:0] imm, input logic [4:0] rs2,
        input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], S_OP};
    endfunction

    function automatic logic [31:0] beq_t(input logic [12:0] imm, input logic [4:0] rs2,
        input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // Expected ID/EX contents for the instruction currently being driven.
    task automatic push_exp(input logic [31:0] o1, input logic [31:0] o2, input logic [31:0] o3,
        input logic [31:0] off, input logic [4:0] rd, input logic we, input logic [3:0] alu);
        exp_t e;
        e = '{op1: o1, op2: o2, op3: o3, off: off, rd: rd, we: we, alu: alu,
              pc: in_pc, inst: in_inst};
        sb.push_back(e);
    endtask

    task automatic settle();
        #1;
    endtask

    // One clock: compare an output being consumed, then advance past the edge.
    task automatic step();
        exp_t e;
        #1;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("issue_without_expect", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check("op_1", op_1, e.op1);
                check("op_2", op_2, e.op2);
                check("op_3", op_3, e.op3);
                check("mem_offset", mem_offset, e.off);
                check("rd_addr", 32'(rd_addr), 32'(e.rd));
                check("rd_we", 32'(rd_we), 32'(e.we));
                check("alu_op", 32'(alu_op), 32'(e.alu));
                check("pc_out", pc_out, e.pc);
                check("ID_inst", ID_inst, e.inst);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    logic [31:0] add_w;

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[0]      = 32'hDEADBEEF;
        reset_n    = 1'b0;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        fwd_valid  = '0;
        fwd_addr   = '0;
        fwd_data   = '0;
        ex_is_load = 1'b0;
        ex_rd_addr = '0;
        add_w      = r_t(7'h00, 5'd2, 5'd1, 3'b000, 5'd3, R_OP);
        in_inst    = add_w;
        in_pc      = 32'h10;

        // Reset held with an instruction offered.
        repeat (3) begin
            step();
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_br", 32'(br), 32'd0);
            check("rst_op_1", op_1, 32'd0);
            check("rst_pc_out", pc_out, 32'd0);
            check("rst_ID_inst", ID_inst, 32'd0);
            check("rst_rd_we", 32'(rd_we), 32'd0);
        end

        // Forward priority: index 0 beats index 1.
        reset_n  = 1'b1;
        rf[1]    = 32'h33;
        rf[2]    = 32'h5;
        fwd_valid = 2'b11;
        fwd_addr  = {5'd1, 5'd1};
        fwd_data  = {32'h22, 32'h11};
        settle();
        check("fwd_in_ready", 32'(in_ready), 32'd1);
        push_exp(32'h11, 32'h5, 0, 0, 5'd3, 1'b1, A_ADD);
        step();
        check("latency_out_valid", 32'(out_valid), 32'd1);
        // Different sources on different operands.
        in_pc     = 32'h14;
        fwd_addr  = {5'd1, 5'd2};
        fwd_data  = {32'h22, 32'h99};
        push_exp(32'h22, 32'h99, 0, 0, 5'd3, 1'b1, A_ADD);
        step();
        in_valid  = 1'b0;
        fwd_valid = '0;
        step();
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Load-use stall then release.
        in_valid   = 1'b1;
        ex_is_load = 1'b1;
        ex_rd_addr = 5'd4;
        rf[4]      = 32'h44;
        in_inst    = r_t(7'h00, 5'd1, 5'd4, 3'b000, 5'd5, R_OP);
        in_pc      = 32'h20;
        settle();
        check("lu_in_ready", 32'(in_ready), 32'd0);
        step();
        check("lu_bubble", 32'(out_valid), 32'd0);
`ifdef ID_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 32'd1);
`endif
        ex_is_load = 1'b0;
        settle();
        check("lu_release_ready", 32'(in_ready), 32'd1);
        push_exp(32'h44, 32'h33, 0, 0, 5'd5, 1'b1, A_ADD);
        step();
        check("lu_issue", 32'(out_valid), 32'd1);
        // Load to x0 never stalls.
        ex_is_load = 1'b1;
        ex_rd_addr = 5'd0;
        in_inst    = r_t(7'h00, 5'd1, 5'd0, 3'b000, 5'd3, R_OP);
        in_pc      = 32'h24;
        settle();
        check("lu_x0_ready", 32'(in_ready), 32'd1);
        push_exp(0, 32'h33, 0, 0, 5'd3, 1'b1, A_ADD);
        step();
        // ADDI immediate field aliases x4 in the rs2 slot; rs2 is unused.
        ex_rd_addr = 5'd4;
        in_inst    = i_t(12'd4, 5'd1, 3'b000, 5'd9, I_OP);
        in_pc      = 32'h28;
        settle();
        check("lu_disabled_ready", 32'(in_ready), 32'd1);
        check("addi_r2_en", 32'(r2_read_enable), 32'd0);
        check("addi_r2_addr", 32'(r2_addr), 32'd0);
        push_exp(32'h33, 32'h4, 0, 0, 5'd9, 1'b1, A_ADD);
        step();
        ex_is_load = 1'b0;

        // Taken BEQ, then the wrong-path ADDI is squashed.
        rf[1]   = 32'h7;
        rf[2]   = 32'h7;
        in_inst = beq_t(13'd16, 5'd2, 5'd1);
        in_pc   = 32'h100;
        push_exp(32'h7, 32'h7, 0, 0, 5'd0, 1'b0, A_SUB);
        step();
        check("taken_br", 32'(br), 32'd1);
        check("taken_addr", branch_addr, 32'h110);
        in_inst = i_t(12'd5, 5'd1, 3'b000, 5'd9, I_OP);
        in_pc   = 32'h104;
        settle();
        check("squash_in_ready", 32'(in_ready), 32'd1);
        step();
        check("br_one_cycle", 32'(br), 32'd0);
        check("squash_out_valid", 32'(out_valid), 32'd0);
`ifdef ID_PERF_CNT_EN
        check("squash_cnt", squash_cnt, 32'd1);
        check("taken_cnt", taken_cnt, 32'd1);
`endif
        // Not-taken BEQ, then a negative-immediate ADDI issues.
        rf[2]   = 32'h8;
        in_inst = beq_t(-13'sd8, 5'd2, 5'd1);
        in_pc   = 32'h200;
        push_exp(32'h7, 32'h8, 0, 0, 5'd0, 1'b0, A_SUB);
        step();
        check("not_taken_br", 32'(br), 32'd0);
        in_inst = i_t(12'hFFD, 5'd1, 3'b000, 5'd9, I_OP);
        in_pc   = 32'h204;
        push_exp(32'h7, 32'hFFFF_FFFD, 0, 0, 5'd9, 1'b1, A_ADD);
        step();
        check("after_nt_valid", 32'(out_valid), 32'd1);
        // Backward taken branch.
        rf[2]   = 32'h7;
        in_inst = beq_t(-13'sd8, 5'd2, 5'd1);
        in_pc   = 32'h300;
        push_exp(32'h7, 32'h7, 0, 0, 5'd0, 1'b0, A_SUB);
        step();
        check("back_br", 32'(br), 32'd1);
        check("back_addr", branch_addr, 32'h2F8);
        in_valid = 1'b0;
        step();
        // Branch compare sees the forwarded operand.
        in_valid  = 1'b1;
        rf[1]     = 32'h1;
        rf[2]     = 32'h2;
        fwd_valid = 2'b01;
        fwd_addr  = {5'd0, 5'd2};
        fwd_data  = {32'h0, 32'h1};
        in_inst   = beq_t(13'd8, 5'd2, 5'd1);
        in_pc     = 32'h400;
        push_exp(32'h1, 32'h1, 0, 0, 5'd0, 1'b0, A_SUB);
        step();
        check("fwd_br", 32'(br), 32'd1);
        check("fwd_br_addr", branch_addr, 32'h408);
        fwd_valid = '0;
        in_valid  = 1'b0;
        step();

        // Backpressure: outputs hold and input waits.
        in_valid = 1'b1;
        rf[1]    = 32'h7;
        rf[2]    = 32'h8;
        in_inst  = add_w;
        in_pc    = 32'h500;
        push_exp(32'h7, 32'h8, 0, 0, 5'd3, 1'b1, A_ADD);
        step();
        out_ready = 1'b0;
        in_inst   = s_t(12'd12, 5'd2, 5'd1);
        in_pc     = 32'h504;
        repeat (4) begin
            settle();
            check("bp_in_ready", 32'(in_ready), 32'd0);
            step();
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_op_1", op_1, 32'h7);
            check("bp_op_2", op_2, 32'h8);
            check("bp_inst", ID_inst, add_w);
            check("bp_pc", pc_out, 32'h500);
        end
        out_ready = 1'b1;
        settle();
        check("bp_release_ready", 32'(in_ready), 32'd1);
        push_exp(32'h7, 32'h8, 0, 32'd12, 5'd0, 1'b0, A_ADD);
        step();
        check("sw_issue", 32'(out_valid), 32'd1);
        in_inst = i_t(12'hFFC, 5'd1, 3'b010, 5'd10, L_OP);
        in_pc   = 32'h508;
        push_exp(32'h7, 0, 0, 32'hFFFF_FFFC, 5'd10, 1'b1, A_ADD);
        step();
        in_inst = r_t(7'h20, 5'd2, 5'd1, 3'b101, 5'd3, R_OP);
        in_pc   = 32'h50C;
        push_exp(32'h7, 32'h8, 0, 0, 5'd3, 1'b1, A_SRA);
        step();

        // MAC with three sources, then forwarding on rs3, then x0 handling.
        rf[6]   = 32'd10;
        rf[7]   = 32'd2;
        rf[8]   = 32'd3;
        in_inst = r_t(7'h00, 5'd8, 5'd7, 3'b000, 5'd6, M_OP);
        in_pc   = 32'h600;
        push_exp(32'd2, 32'd3, 32'd10, 0, 5'd6, 1'b1, A_MAC);
        step();
        fwd_valid = 2'b10;
        fwd_addr  = {5'd6, 5'd0};
        fwd_data  = {32'h66, 32'h0};
        in_pc     = 32'h604;
        push_exp(32'd2, 32'd3, 32'h66, 0, 5'd6, 1'b1, A_MAC);
        step();
        fwd_valid = 2'b01;
        fwd_addr  = {5'd0, 5'd0};
        fwd_data  = {32'h0, 32'hFF};
        in_inst   = r_t(7'h00, 5'd0, 5'd0, 3'b000, 5'd1, R_OP);
        in_pc     = 32'h608;
        push_exp(0, 0, 0, 0, 5'd1, 1'b1, A_ADD);
        step();
        fwd_valid = '0;

        // Unknown opcode and unknown funct are accepted bubbles.
        in_inst = 32'h0000_007F;
        in_pc   = 32'h700;
        settle();
        check("unk_ready", 32'(in_ready), 32'd1);
        check("unk_r1_en", 32'(r1_read_enable), 32'd0);
        step();
        check("unk_bubble", 32'(out_valid), 32'd0);
        in_inst = r_t(7'h01, 5'd2, 5'd1, 3'b000, 5'd3, R_OP);
        step();
        check("unk_funct_bubble", 32'(out_valid), 32'd0);

        // Reset during a stall and right after a taken branch.
        ex_is_load = 1'b1;
        ex_rd_addr = 5'd4;
        in_inst    = r_t(7'h00, 5'd1, 5'd4, 3'b000, 5'd5, R_OP);
        step();
        reset_n = 1'b0;
        step();
        check("rst_stall_valid", 32'(out_valid), 32'd0);
        reset_n    = 1'b1;
        ex_is_load = 1'b0;
        rf[1]      = 32'h7;
        rf[2]      = 32'h7;
        in_inst    = beq_t(13'd16, 5'd2, 5'd1);
        in_pc      = 32'h800;
        push_exp(32'h7, 32'h7, 0, 0, 5'd0, 1'b0, A_SUB);
        step();
        check("pre_rst_br", 32'(br), 32'd1);
        reset_n  = 1'b0;
        in_valid = 1'b0;
        step();
        check("rst_br_clear", 32'(br), 32'd0);
        check("rst_br_valid", 32'(out_valid), 32'd0);
`ifdef ID_PERF_CNT_EN
        check("rst_taken_cnt", taken_cnt, 32'd0);
`endif
        reset_n = 1'b1;
        step();
        step();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
